// File: rtl/arg_x_stream_reader.sv
// Avalon-MM read master for the argument-x RAM s2 port; streams a run of consecutive words with an end-of-run marker.
// First word valid two cycles after start, then one word per cycle; reads stall whenever the skid FIFO could not absorb them.
module arg_x_stream_reader #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     ram_address,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   input  logic [DATA_W-1:0]     ram_readdata,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [ADDR_W:0]       issue_left_q;
   logic [ADDR_W:0]       accept_left_q;
   logic [ADDR_W:0]       cnt_clip;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic [DATA_W-1:0]     fifo_dat_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]      occ_q, occ_after_pop;
   logic [OCC_W:0]        need;
   logic                  fifo_nempty, push, pop, room;
   logic                  idle_issue, fetch_issue, issue, issue_last;

   assign cnt_clip      = (count > MAX_CNT) ? MAX_CNT : count;
   assign fifo_nempty   = (occ_q != '0);
   assign push          = inflight_q;
   assign pop           = fifo_nempty & out_ready;
   assign occ_after_pop = occ_q - OCC_W'(pop);
   // A read may go out only if its word is guaranteed a slot when it lands next cycle.
   assign need          = (OCC_W+1)'(occ_after_pop) + (OCC_W+1)'(inflight_q) + (OCC_W+1)'(1);
   assign room          = (need <= (OCC_W+1)'(FIFO_DEPTH));

   // The first read is issued in the start cycle itself, straight from base_addr.
   assign idle_issue  = (state_q == S_IDLE) && start && !reset && (cnt_clip != '0);
   assign fetch_issue = (state_q == S_FETCH) && !reset && (issue_left_q != '0) && room;
   assign issue       = idle_issue | fetch_issue;
   assign issue_last  = idle_issue ? (cnt_clip == ONE_CNT) : (issue_left_q == ONE_CNT);

   assign ram_write      = 1'b0;
   assign ram_byteenable = '1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cnt_clip == '0)           state_d = S_DONE;
               else if (cnt_clip == ONE_CNT) state_d = S_DRAIN;
               else                          state_d = S_FETCH;
            end
         end
         S_FETCH: if (fetch_issue && (issue_left_q == ONE_CNT)) state_d = S_DRAIN;
         S_DRAIN: if (pop && (accept_left_q == ONE_CNT))        state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_FETCH, S_DRAIN: busy = 1'b1;
         S_DONE:           done = 1'b1;
         default:          ;
      endcase
      ram_chipselect = issue;
      ram_address    = idle_issue ? base_addr : addr_q;
      out_valid      = fifo_nempty;
      out_data       = fifo_nempty ? fifo_dat_q[rd_ptr_q] : '0;
      out_last       = fifo_nempty & fifo_last_q[rd_ptr_q];
   end

   // Reset drops any read in flight, so its return data never reaches the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q          <= '0;
         issue_left_q    <= '0;
         accept_left_q   <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         occ_q           <= '0;
         fifo_last_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_dat_q[i] <= '0;
         end
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue & issue_last;
         if ((state_q == S_IDLE) && start) begin
            addr_q        <= base_addr + ADDR_W'(idle_issue);
            issue_left_q  <= cnt_clip - (ADDR_W+1)'(idle_issue);
            accept_left_q <= cnt_clip;
         end else begin
            if (fetch_issue) begin
               addr_q       <= addr_q + ADDR_W'(1);
               issue_left_q <= issue_left_q - ONE_CNT;
            end
            if (pop) begin
               accept_left_q <= accept_left_q - ONE_CNT;
            end
         end
         if (push) begin
            fifo_dat_q[wr_ptr_q]  <= ram_readdata;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
      end
   end

endmodule

// File: tb/tb_arg_x_stream_reader.sv
// Directed bench for arg_x_stream_reader with a one-cycle-latency RAM model and a stream monitor.
module tb_arg_x_stream_reader;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  base_addr;
   logic [5:0]  count;
   logic        busy, done;
   logic [4:0]  ram_address;
   logic        ram_chipselect, ram_write;
   logic [7:0]  ram_byteenable;
   logic [63:0] ram_readdata;
   logic [63:0] out_data;
   logic        out_valid, out_ready, out_last;

   arg_x_stream_reader dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .count          (count),
      .busy           (busy),
      .done           (done),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_byteenable (ram_byteenable),
      .ram_readdata   (ram_readdata),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: registered address, unregistered output.
   logic [63:0] ram_mem [32];
   logic [4:0]  ram_addr_r;
   always @(posedge clk) if (ram_chipselect) ram_addr_r <= ram_address;
   assign ram_readdata = ram_mem[ram_addr_r];

   // Monitor: logs reads/accepted words and tracks an independent occupancy model.
   logic [63:0] got_dat [$];
   bit          got_last [$];
   int          addr_log [$];
   int          done_cnt = 0, busy_cnt = 0;
   int          over_viol = 0, occ_viol = 0, vld_viol = 0, stab_viol = 0;
   int          occ_m = 0, infl_m = 0, pop_m;
   bit          prev_stall = 0, prev_last;
   logic [63:0] prev_dat;

   always @(negedge clk) begin
      if (reset) begin
         occ_m = 0;
         infl_m = 0;
         prev_stall = 0;
      end else begin
         pop_m = (out_valid && out_ready) ? 1 : 0;
         if (out_valid !== (occ_m != 0)) vld_viol++;
         if (occ_m > DEPTH) occ_viol++;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_dat || out_last !== prev_last)) stab_viol++;
         if (ram_chipselect) begin
            addr_log.push_back(int'(ram_address));
            if (occ_m - pop_m + infl_m + 1 > DEPTH) over_viol++;
         end
         if (pop_m == 1) begin
            got_dat.push_back(out_data);
            got_last.push_back(out_last);
         end
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_data;
         prev_last  = out_last;
         occ_m  = occ_m + infl_m - pop_m;
         infl_m = ram_chipselect ? 1 : 0;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input int max_cyc, input bit toggle, input int inject, output bit seen);
      logic [0:3] rdy_pat;
      rdy_pat = 4'b1001;
      seen = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         step();
         start = (c == inject);
         if (c == inject) begin
            base_addr = 5'd0;
            count     = 6'd5;
         end
         if (toggle) out_ready = rdy_pat[c % 4];
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_run(input string tag, input int w0, input int a0, input int base, input int n);
      logic [63:0] exp;
      chk($sformatf("%s_nreads", tag), 64'(addr_log.size() - a0), 64'(n));
      chk($sformatf("%s_nwords", tag), 64'(got_dat.size() - w0), 64'(n));
      for (int i = 0; i < n; i++) begin
         exp = 64'hA5A5_0000_0000_0000 + 64'((base + i) % 32);
         if (a0 + i < addr_log.size())
            chk($sformatf("%s_addr%0d", tag, i), 64'(addr_log[a0 + i]), 64'((base + i) % 32));
         if (w0 + i < got_dat.size()) begin
            chk($sformatf("%s_data%0d", tag, i), got_dat[w0 + i], exp);
            chk($sformatf("%s_last%0d", tag, i), 64'(got_last[w0 + i]), 64'(i == n - 1));
         end
      end
   endtask

   initial begin
      int  w0, a0, d0, b0;
      bit  seen;

      reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
      for (int k = 0; k < 32; k++) ram_mem[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
      repeat (2) step();

      // Reset values
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_cs", 64'(ram_chipselect), 64'(0));
      chk("rst_addr", 64'(ram_address), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_last", 64'(out_last), 64'(0));
      chk("rst_data", out_data, 64'(0));
      chk("ram_write", 64'(ram_write), 64'(0));
      chk("ram_be", 64'(ram_byteenable), 64'hFF);
      reset = 1'b0;
      step();

      // base 0, count 4, cycle-exact timing
      w0 = got_dat.size(); a0 = addr_log.size(); d0 = done_cnt;
      base_addr = 5'd0; count = 6'd4; start = 1'b1;
      #1;
      chk("t1_cs_c0", 64'(ram_chipselect), 64'(1));
      chk("t1_addr_c0", 64'(ram_address), 64'(0));
      for (int k = 1; k <= 6; k++) begin
         step();
         start = 1'b0;
         chk($sformatf("t1_busy_c%0d", k), 64'(busy), 64'(k <= 5));
         chk($sformatf("t1_valid_c%0d", k), 64'(out_valid), 64'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5)
            chk($sformatf("t1_data_c%0d", k), out_data, 64'hA5A5_0000_0000_0000 + 64'(k - 2));
         chk($sformatf("t1_last_c%0d", k), 64'(out_last), 64'(k == 5));
         chk($sformatf("t1_done_c%0d", k), 64'(done), 64'(k == 6));
      end
      step();
      chk("t1_done_once", 64'(done_cnt - d0), 64'(1));
      check_run("t1", w0, a0, 0, 4);

      // Address wrap-around
      w0 = got_dat.size(); a0 = addr_log.size(); d0 = done_cnt;
      base_addr = 5'd30; count = 6'd4; start = 1'b1;
      run_until_done(20, 1'b0, -1, seen);
      chk("t2_done_seen", 64'(seen), 64'(1));
      step();
      chk("t2_done_once", 64'(done_cnt - d0), 64'(1));
      check_run("t2", w0, a0, 30, 4);

      // Stalling sink, start during run and during DONE ignored
      w0 = got_dat.size(); a0 = addr_log.size(); d0 = done_cnt;
      base_addr = 5'd10; count = 6'd8; start = 1'b1; out_ready = 1'b1;
      run_until_done(80, 1'b1, 3, seen);
      chk("t3_done_seen", 64'(seen), 64'(1));
      out_ready = 1'b1; start = 1'b1; base_addr = 5'd0; count = 6'd5;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("t3_idle_busy", 64'(busy), 64'(0));
      chk("t3_done_once", 64'(done_cnt - d0), 64'(1));
      check_run("t3", w0, a0, 10, 8);
      chk("t3_overissue", 64'(over_viol), 64'(0));
      chk("t3_stable", 64'(stab_viol), 64'(0));
      chk("t3_occ", 64'(occ_viol), 64'(0));
      chk("t3_valid_model", 64'(vld_viol), 64'(0));

      // count = 0
      a0 = addr_log.size(); d0 = done_cnt;
      base_addr = 5'd7; count = 6'd0; start = 1'b1;
      #1;
      chk("t4_cs_c0", 64'(ram_chipselect), 64'(0));
      step();
      start = 1'b0;
      chk("t4_done_c1", 64'(done), 64'(1));
      chk("t4_busy_c1", 64'(busy), 64'(0));
      step();
      chk("t4_done_c2", 64'(done), 64'(0));
      chk("t4_busy_c2", 64'(busy), 64'(0));
      chk("t4_nreads", 64'(addr_log.size() - a0), 64'(0));
      chk("t4_done_once", 64'(done_cnt - d0), 64'(1));

      // Reset in FETCH with a read in flight
      d0 = done_cnt;
      out_ready = 1'b0; base_addr = 5'd3; count = 6'd10; start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_busy_fetch", 64'(busy), 64'(1));
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5_rst_busy", 64'(busy), 64'(0));
      chk("t5_rst_done", 64'(done), 64'(0));
      chk("t5_rst_cs", 64'(ram_chipselect), 64'(0));
      chk("t5_rst_addr", 64'(ram_address), 64'(0));
      chk("t5_rst_valid", 64'(out_valid), 64'(0));
      chk("t5_rst_last", 64'(out_last), 64'(0));
      chk("t5_rst_data", out_data, 64'(0));
      step();
      chk("t5_no_stale_valid", 64'(out_valid), 64'(0));
      repeat (3) step();
      chk("t5_no_done", 64'(done_cnt - d0), 64'(0));
      w0 = got_dat.size(); a0 = addr_log.size(); d0 = done_cnt;
      out_ready = 1'b1; base_addr = 5'd20; count = 6'd3; start = 1'b1;
      run_until_done(20, 1'b0, -1, seen);
      chk("t5_done_seen", 64'(seen), 64'(1));
      step();
      chk("t5_done_once", 64'(done_cnt - d0), 64'(1));
      check_run("t5", w0, a0, 20, 3);

      // Full 32-word run from base 5
      w0 = got_dat.size(); a0 = addr_log.size(); d0 = done_cnt; b0 = busy_cnt;
      base_addr = 5'd5; count = 6'd32; start = 1'b1;
      run_until_done(80, 1'b0, -1, seen);
      chk("t6_done_seen", 64'(seen), 64'(1));
      repeat (2) step();
      chk("t6_busy_cycles", 64'(busy_cnt - b0), 64'(33));
      chk("t6_done_once", 64'(done_cnt - d0), 64'(1));
      check_run("t6", w0, a0, 5, 32);

      // count above 32 is clipped
      a0 = addr_log.size(); d0 = done_cnt;
      base_addr = 5'd0; count = 6'd40; start = 1'b1;
      run_until_done(80, 1'b0, -1, seen);
      chk("t7_done_seen", 64'(seen), 64'(1));
      step();
      chk("t7_nreads", 64'(addr_log.size() - a0), 64'(32));
      chk("t7_done_once", 64'(done_cnt - d0), 64'(1));

      chk("end_overissue", 64'(over_viol), 64'(0));
      chk("end_stable", 64'(stab_viol), 64'(0));
      chk("end_occ", 64'(occ_viol), 64'(0));
      chk("end_valid_model", 64'(vld_viol), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
